// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start/data/parity/stop framing, LSB-first data,
// XOR parity check and framing check reported alongside each received word.
module parity_frame_rx #(
   parameter int DATA_W = 8,
   parameter bit ODD    = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin,
   input  logic              bit_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [DATA_W-1:0]  r_shift;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_acc;
   logic               r_perr;
   logic [DATA_W-1:0]  r_dout;
   logic               r_dout_valid;
   logic               r_parity_err;
   logic               r_frame_err;
   logic               w_last_data;

   // Accumulated data parity plus the received parity bit must equal the parity sense.
   function automatic logic parity_mismatch(input logic acc, input logic par_bit);
      return ((acc ^ par_bit) != ODD);
   endfunction

   assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; every transition is gated by the bit strobe.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bit_en && !sin) w_next = DATA;
            else                w_next = IDLE;
         end
         DATA: begin
            if (bit_en && w_last_data) w_next = PARITY;
            else                       w_next = DATA;
         end
         PARITY: begin
            if (bit_en) w_next = STOP;
            else        w_next = PARITY;
         end
         STOP: begin
            if (bit_en) w_next = IDLE;
            else        w_next = STOP;
         end
         default: w_next = IDLE;
      endcase
   end

   // Datapath: shift/accumulate while framing, publish results on the stop bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift      <= '0;
         r_cnt        <= '0;
         r_acc        <= 1'b0;
         r_perr       <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         if (bit_en) begin
            case (r_state)
               IDLE: begin
                  if (!sin) begin
                     r_shift <= '0;
                     r_cnt   <= '0;
                     r_acc   <= 1'b0;
                  end
               end
               DATA: begin
                  r_shift <= {sin, r_shift[DATA_W-1:1]};
                  r_acc   <= r_acc ^ sin;
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
               PARITY: begin
                  r_perr <= parity_mismatch(r_acc, sin);
               end
               STOP: begin
                  r_dout       <= r_shift;
                  r_parity_err <= r_perr;
                  r_frame_err  <= ~sin;
                  r_dout_valid <= 1'b1;
               end
               default: begin
                  r_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even and odd instances share one serial line;
// a behavioural model predicts every delivered word and its error flags.
module tb_parity_frame_rx;

   logic       clk;
   logic       rst_n;
   logic       sin;
   logic       bit_en;
   logic [7:0] dout_e, dout_o;
   logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

   int tests = 0;
   int fails = 0;
   int dbl_e = 0;
   int dbl_o = 0;
   logic prev_e = 1'b0;
   logic prev_o = 1'b0;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } rec_t;

   rec_t cap_e[$], cap_o[$], exp_e[$], exp_o[$];

   parity_frame_rx #(.DATA_W(8), .ODD(1'b0)) u_even (
      .clk(clk), .rst_n(rst_n), .sin(sin), .bit_en(bit_en),
      .dout(dout_e), .dout_valid(dv_e), .parity_err(pe_e),
      .frame_err(fe_e), .busy(busy_e)
   );

   parity_frame_rx #(.DATA_W(8), .ODD(1'b1)) u_odd (
      .clk(clk), .rst_n(rst_n), .sin(sin), .bit_en(bit_en),
      .dout(dout_o), .dout_valid(dv_o), .parity_err(pe_o),
      .frame_err(fe_o), .busy(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every delivered word and detect pulses longer than one cycle.
   always @(negedge clk) begin
      if (dv_e) cap_e.push_back({dout_e, pe_e, fe_e});
      if (dv_o) cap_o.push_back({dout_o, pe_o, fe_o});
      if (dv_e && prev_e) dbl_e <= dbl_e + 1;
      if (dv_o && prev_o) dbl_o <= dbl_o + 1;
      prev_e <= dv_e;
      prev_o <= dv_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: a frame is wrong-parity when the count of ones in data+parity
   // bit has the wrong oddness for the selected sense.
   function automatic logic model_perr(input logic [7:0] d, input logic p, input int odd);
      return ((($countones(d) + int'(p)) % 2) != odd);
   endfunction

   task automatic drive_bit(input logic b, input int gap);
      @(negedge clk);
      bit_en = 1'b1;
      sin    = b;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bit_en = 1'b0;
         sin    = 1'($urandom);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic stopb, input int gap);
      drive_bit(1'b0, gap);
      for (int i = 0; i < 8; i++) drive_bit(d[i], gap);
      drive_bit(p, gap);
      drive_bit(stopb, gap);
      exp_e.push_back({d, model_perr(d, p, 0), ~stopb});
      exp_o.push_back({d, model_perr(d, p, 1), ~stopb});
   endtask

   task automatic idle_line(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bit_en = 1'($urandom);
         sin    = 1'b1;
      end
   endtask

   task automatic flush();
      repeat (3) begin
         @(negedge clk);
         bit_en = 1'b0;
         sin    = 1'b1;
      end
   endtask

   task automatic compare_queues(input string tag);
      rec_t a, b;
      chk({tag, "_count_even"}, 32'(cap_e.size()), 32'(exp_e.size()));
      chk({tag, "_count_odd"},  32'(cap_o.size()), 32'(exp_o.size()));
      while (exp_e.size() > 0 && cap_e.size() > 0) begin
         a = cap_e.pop_front();
         b = exp_e.pop_front();
         chk({tag, "_even_word"}, 32'(a), 32'(b));
      end
      while (exp_o.size() > 0 && cap_o.size() > 0) begin
         a = cap_o.pop_front();
         b = exp_o.pop_front();
         chk({tag, "_odd_word"}, 32'(a), 32'(b));
      end
      exp_e.delete(); exp_o.delete(); cap_e.delete(); cap_o.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       p, stopb;
      int         gap;

      rst_n  = 1'b0;
      bit_en = 1'b0;
      sin    = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_dout",  32'(dout_e), 32'h0);
      chk("rst_valid", 32'(dv_e),   32'h0);
      chk("rst_flags", 32'({pe_e, fe_e, pe_o, fe_o}), 32'h0);
      chk("rst_busy",  32'({busy_e, busy_o}), 32'h0);
      rst_n = 1'b1;

      // Good frame 0xA5, contiguous strobes, exact latency and pulse width.
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      @(negedge clk);
      bit_en = 1'b0;
      chk("lat_valid", 32'(dv_e), 32'h1);
      chk("lat_dout",  32'(dout_e), 32'hA5);
      chk("lat_flags", 32'({pe_e, fe_e}), 32'h0);
      chk("lat_busy",  32'(busy_e), 32'h0);
      @(negedge clk);
      chk("pulse_end", 32'(dv_e), 32'h0);
      chk("hold_dout", 32'(dout_e), 32'hA5);

      // Parity bit 1: even instance flags it, odd instance accepts it.
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      flush();
      chk("perr_even", 32'(pe_e), 32'h1);
      chk("perr_odd",  32'(pe_o), 32'h0);

      // Framing error followed immediately by a clean frame.
      send_frame(8'h01, 1'b1, 1'b0, 0);
      send_frame(8'h7E, 1'b0, 1'b1, 0);
      flush();
      compare_queues("basic");

      // Gapped strobes with idle-high strobes around the frame.
      idle_line(6);
      chk("idle_busy", 32'(busy_e), 32'h0);
      send_frame(8'h5A, 1'b0, 1'b1, 3);
      idle_line(5);
      chk("gap_busy", 32'(busy_e), 32'h0);
      flush();
      compare_queues("gapped");

      // Back-to-back frames with no idle bits between them.
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      send_frame(8'h00, 1'b0, 1'b1, 0);
      flush();
      compare_queues("b2b");

      // Reset mid-frame after three data bits discards the frame.
      drive_bit(1'b0, 0);
      drive_bit(1'b1, 0);
      drive_bit(1'b0, 0);
      drive_bit(1'b1, 0);
      @(negedge clk);
      bit_en = 1'b0;
      chk("mid_busy", 32'(busy_e), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dout", 32'(dout_e), 32'h0);
      chk("mid_rst_busy", 32'({busy_e, busy_o}), 32'h0);
      chk("mid_rst_flags", 32'({dv_e, pe_e, fe_e}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b1, 0);
      flush();
      compare_queues("post_rst");

      // Randomized frames: random data, parity, stop, strobe gaps and idle.
      for (int n = 0; n < 40; n++) begin
         d     = 8'($urandom_range(0, 255));
         p     = 1'($countones(d) % 2);
         if ($urandom_range(0, 3) == 0) p = ~p;
         stopb = ($urandom_range(0, 4) != 0);
         gap   = $urandom_range(0, 3);
         send_frame(d, p, stopb, gap);
         idle_line($urandom_range(0, 3));
      end
      flush();
      compare_queues("random");

      chk("single_pulse_even", 32'(dbl_e), 32'h0);
      chk("single_pulse_odd",  32'(dbl_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
